// File: rtl/cnn_pkg.sv
// Shared CNN datapath types: FSM state encoding and default frame geometry.
package cnn_pkg;

    localparam int PIX_WIDTH_DEF = 8;
    localparam int N_CH_DEF      = 8;
    localparam int CH_LEN_DEF    = 25;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_FILL = 3'b010,
        ST_SEND = 3'b100
    } state_e;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pkt_buffer.sv
// Simple dual-port frame RAM with registered read; no reset on contents.
module pkt_buffer
    import cnn_pkg::*;
#(
    parameter int WIDTH = PIX_WIDTH_DEF,
    parameter int DEPTH = N_CH_DEF * CH_LEN_DEF,
    parameter int AW    = addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             clk_en,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (clk_en) begin
            if (we_i) mem_q[waddr_i] <= wdata_i;
            if (re_i) rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/flatten_packetizer.sv
// Collects N_CH framed channels into one buffer, then replays them
// as a single flattened packet with valid/ready and a skid register.
module flatten_packetizer
    import cnn_pkg::*;
#(
    parameter int PIX_WIDTH = PIX_WIDTH_DEF,
    parameter int N_CH      = N_CH_DEF,
    parameter int CH_LEN    = CH_LEN_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clk_en,
    input  logic [PIX_WIDTH-1:0] i_data,
    input  logic                 i_valid,
    input  logic                 i_sop,
    input  logic                 i_eop,
    output logic                 o_in_ready,
    output logic [PIX_WIDTH-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_sop,
    output logic                 o_eop,
    input  logic                 i_ready,
    output logic                 o_err
);

    localparam int DIM = N_CH * CH_LEN;
    localparam int AW  = addr_w(DIM);
    localparam int PW  = addr_w(CH_LEN);
    localparam logic [AW-1:0] LAST_A = AW'(DIM - 1);
    localparam logic [PW-1:0] LAST_P = PW'(CH_LEN - 1);

    state_e state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] pos_q, pos_d;
    logic rd_done_q, rd_done_d;
    logic rdy_q, rdy_d;
    logic err_q, err_d;
    logic rv_q, rv_d;
    logic r_sop_q, r_sop_d;
    logic r_eop_q, r_eop_d;
    logic sk_v_q, sk_v_d;
    logic sk_sop_q, sk_sop_d;
    logic sk_eop_q, sk_eop_d;
    logic [PIX_WIDTH-1:0] sk_q, sk_d;
    logic [PIX_WIDTH-1:0] rd_data;
    logic we, re, accept, frame_ok, fire;

    assign accept   = i_valid & rdy_q;
    assign frame_ok = (i_sop == (pos_q == '0)) &&
                      (i_eop == (pos_q == LAST_P));

    // Reads are only issued while the skid slot is empty, so a
    // stalled RAM beat always has somewhere to go.
    assign re = (state_q == ST_SEND) & ~rd_done_q & ~sk_v_q;

    assign o_valid = sk_v_q | rv_q;
    assign o_data  = sk_v_q ? sk_q : (rv_q ? rd_data : '0);
    assign o_sop   = sk_v_q ? sk_sop_q : (rv_q & r_sop_q);
    assign o_eop   = sk_v_q ? sk_eop_q : (rv_q & r_eop_q);
    assign fire    = o_valid & i_ready;

    assign o_in_ready = rdy_q;
    assign o_err      = err_q;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        pos_d     = pos_q;
        rd_done_d = rd_done_q;
        rdy_d     = rdy_q;
        err_d     = 1'b0;
        rv_d      = rv_q;
        r_sop_d   = r_sop_q;
        r_eop_d   = r_eop_q;
        sk_v_d    = sk_v_q;
        sk_d      = sk_q;
        sk_sop_d  = sk_sop_q;
        sk_eop_d  = sk_eop_q;
        we        = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_FILL: begin
                if (accept && (state_q == ST_FILL || i_sop)) begin
                    if (!frame_ok) begin
                        err_d    = 1'b1;
                        state_d  = ST_IDLE;
                        wr_ptr_d = '0;
                        pos_d    = '0;
                    end else begin
                        we = 1'b1;
                        if (wr_ptr_q == LAST_A) begin
                            state_d   = ST_SEND;
                            rdy_d     = 1'b0;
                            wr_ptr_d  = '0;
                            pos_d     = '0;
                            rd_ptr_d  = '0;
                            rd_done_d = 1'b0;
                        end else begin
                            state_d  = ST_FILL;
                            wr_ptr_d = wr_ptr_q + 1'b1;
                            pos_d    = (pos_q == LAST_P) ? '0 : pos_q + 1'b1;
                        end
                    end
                end
            end
            ST_SEND: begin
                if (sk_v_q) begin
                    if (i_ready) sk_v_d = 1'b0;
                end else if (rv_q && i_ready) begin
                    rv_d = 1'b0;
                end
                if (re) begin
                    if (rv_q && !i_ready) begin
                        sk_v_d   = 1'b1;
                        sk_d     = rd_data;
                        sk_sop_d = r_sop_q;
                        sk_eop_d = r_eop_q;
                    end
                    rv_d    = 1'b1;
                    r_sop_d = (rd_ptr_q == '0);
                    r_eop_d = (rd_ptr_q == LAST_A);
                    if (rd_ptr_q == LAST_A) rd_done_d = 1'b1;
                    else rd_ptr_d = rd_ptr_q + 1'b1;
                end
                if (fire && o_eop) begin
                    state_d = ST_IDLE;
                    rdy_d   = 1'b1;
                    rv_d    = 1'b0;
                    sk_v_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pos_q     <= '0;
            rd_done_q <= 1'b0;
            rdy_q     <= 1'b1;
            err_q     <= 1'b0;
            rv_q      <= 1'b0;
            r_sop_q   <= 1'b0;
            r_eop_q   <= 1'b0;
            sk_v_q    <= 1'b0;
            sk_q      <= '0;
            sk_sop_q  <= 1'b0;
            sk_eop_q  <= 1'b0;
        end else if (clk_en) begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            pos_q     <= pos_d;
            rd_done_q <= rd_done_d;
            rdy_q     <= rdy_d;
            err_q     <= err_d;
            rv_q      <= rv_d;
            r_sop_q   <= r_sop_d;
            r_eop_q   <= r_eop_d;
            sk_v_q    <= sk_v_d;
            sk_q      <= sk_d;
            sk_sop_q  <= sk_sop_d;
            sk_eop_q  <= sk_eop_d;
        end
    end

    pkt_buffer #(
        .WIDTH (PIX_WIDTH),
        .DEPTH (DIM),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .clk_en  (clk_en),
        .we_i    (we),
        .waddr_i (wr_ptr_q),
        .wdata_i (i_data),
        .re_i    (re),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

endmodule

// File: tb/tb_flatten_packetizer.sv
// Bench for flatten_packetizer: directed table, corner sequences, random frames.
module tb_flatten_packetizer;

    localparam int PW  = 8;
    localparam int NC  = 2;
    localparam int CL  = 3;
    localparam int DIM = NC * CL;

    logic clk = 1'b0;
    logic rst_n, clk_en, i_valid, i_sop, i_eop, i_ready;
    logic [PW-1:0] i_data, o_data;
    logic o_in_ready, o_valid, o_sop, o_eop, o_err;

    always #5 clk = ~clk;

    flatten_packetizer #(.PIX_WIDTH(PW), .N_CH(NC), .CH_LEN(CL)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .i_data(i_data), .i_valid(i_valid), .i_sop(i_sop), .i_eop(i_eop),
        .o_in_ready(o_in_ready), .o_data(o_data), .o_valid(o_valid),
        .o_sop(o_sop), .o_eop(o_eop), .i_ready(i_ready), .o_err(o_err)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       s;
        logic       e;
    } beat_t;

    typedef struct packed {
        int         n;
        logic [7:0] base;
        logic [7:0] smask;
        logic [7:0] emask;
        int         xerr;
        int         xn;
        logic [7:0] xbase;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;
    beat_t got_q[$];
    beat_t exp_q[$];
    beat_t m_acc[$];
    int err_seen = 0;
    int err_exp = 0;
    int m_idx = -1;
    bit mon_en = 1'b0;
    bit rr_en = 1'b0;
    bit prev_stall = 1'b0;
    beat_t prev_b;
    vec_t tbl[9];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic sample();
        beat_t b;
        b = {o_data, o_sop, o_eop};
        if (mon_en && prev_stall) begin
            chk("stall_valid", {31'd0, o_valid}, 1);
            chk("stall_hold", {22'd0, b}, {22'd0, prev_b});
        end
        prev_stall = mon_en && rst_n && clk_en && o_valid && !i_ready;
        prev_b = b;
        if (mon_en && rst_n && clk_en && o_valid && i_ready) got_q.push_back(b);
        if (mon_en && rst_n && clk_en && o_err) err_seen++;
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        if (rr_en) i_ready = 1'($urandom_range(0, 1));
    endtask

    // Reference: framing rules applied to the accepted beat stream.
    function automatic void model_beat(input beat_t b);
        int pos;
        if (m_idx < 0) begin
            if (!b.s) return;
            m_idx = 0;
            m_acc.delete();
        end
        pos = m_idx % CL;
        if (b.s != (pos == 0) || b.e != (pos == CL - 1)) begin
            err_exp++;
            m_idx = -1;
            return;
        end
        m_acc.push_back(b);
        m_idx++;
        if (m_idx == DIM) begin
            for (int i = 0; i < DIM; i++)
                exp_q.push_back({m_acc[i].d, i == 0, i == DIM - 1});
            m_idx = -1;
        end
    endfunction

    task automatic put(input beat_t b, input bit use_model);
        int n = 0;
        while (!o_in_ready && n < 200) begin
            i_valid = 1'b0;
            tick();
            n++;
        end
        if (n >= 200) chk("ready_timeout", {31'd0, o_in_ready}, 1);
        i_valid = 1'b1;
        i_data  = b.d;
        i_sop   = b.s;
        i_eop   = b.e;
        if (use_model) model_beat(b);
        tick();
    endtask

    task automatic drain_check(input string nm);
        int n = 0;
        while (got_q.size() < exp_q.size() && n < 500) begin
            tick();
            n++;
        end
        repeat (8) tick();
        chk({nm, "_count"}, got_q.size(), exp_q.size());
        chk({nm, "_err"}, err_seen, err_exp);
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk(nm, {22'd0, got_q[i]}, {22'd0, exp_q[i]});
        got_q.delete();
        exp_q.delete();
        err_seen = 0;
        err_exp = 0;
    endtask

    task automatic drive_frame(input logic [7:0] base);
        for (int i = 0; i < DIM; i++) begin
            i_valid = 1'b1;
            i_data  = base + 8'(i);
            i_sop   = (i % CL == 0);
            i_eop   = (i % CL == CL - 1);
            tick();
        end
        i_valid = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!o_valid && n < 20) begin
            tick();
            n++;
        end
        chk(nm, {31'd0, o_valid}, 1);
    endtask

    initial begin
        tbl[0] = '{6, 8'h01, 8'b0000_1001, 8'b0010_0100, 0, 6, 8'h01};
        tbl[1] = '{2, 8'h01, 8'b0000_0001, 8'b0000_0010, 1, 0, 8'h00};
        tbl[2] = '{6, 8'h10, 8'b0000_1001, 8'b0010_0100, 0, 6, 8'h10};
        tbl[3] = '{6, 8'h30, 8'b0000_0001, 8'b0010_0100, 1, 0, 8'h00};
        tbl[4] = '{4, 8'h40, 8'b0000_0001, 8'b0000_0000, 1, 0, 8'h00};
        tbl[5] = '{7, 8'h50, 8'b0001_0010, 8'b0100_1000, 0, 6, 8'h51};
        tbl[6] = '{2, 8'h60, 8'b0000_0011, 8'b0000_0000, 1, 0, 8'h00};
        tbl[7] = '{5, 8'h70, 8'b0000_1001, 8'b0001_0100, 1, 0, 8'h00};
        tbl[8] = '{6, 8'h90, 8'b0000_1001, 8'b0010_0100, 0, 6, 8'h90};

        rst_n = 1'b0; clk_en = 1'b1; i_valid = 1'b0;
        i_sop = 1'b0; i_eop = 1'b0; i_data = '0; i_ready = 1'b1;
        repeat (3) tick();
        chk("rst_valid", {31'd0, o_valid}, 0);
        chk("rst_sop", {31'd0, o_sop}, 0);
        chk("rst_eop", {31'd0, o_eop}, 0);
        chk("rst_err", {31'd0, o_err}, 0);
        chk("rst_in_ready", {31'd0, o_in_ready}, 1);
        chk("rst_data", {24'd0, o_data}, 0);
        rst_n = 1'b1;
        tick();

        mon_en = 1'b1;
        for (int v = 0; v < 9; v++) begin
            for (int i = 0; i < tbl[v].n; i++)
                put({tbl[v].base + 8'(i), tbl[v].smask[i], tbl[v].emask[i]}, 1'b0);
            i_valid = 1'b0;
            for (int k = 0; k < tbl[v].xn; k++)
                exp_q.push_back({tbl[v].xbase + 8'(k), k == 0, k == tbl[v].xn - 1});
            err_exp = tbl[v].xerr;
            drain_check($sformatf("vec%0d", v));
        end
        mon_en = 1'b0;

        // Exact latency/no-bubble timing, with 0xAA sop beats offered during SEND.
        drive_frame(8'h01);
        chk("lat_c1_valid", {31'd0, o_valid}, 0);
        chk("lat_c1_in_ready", {31'd0, o_in_ready}, 0);
        i_valid = 1'b1; i_data = 8'hAA; i_sop = 1'b1; i_eop = 1'b0;
        tick();
        chk("lat_c2_valid", {31'd0, o_valid}, 1);
        chk("lat_c2_beat", {22'd0, o_data, o_sop, o_eop}, {22'd0, 8'h01, 1'b1, 1'b0});
        for (int k = 2; k <= DIM; k++) begin
            tick();
            chk("stream_valid", {31'd0, o_valid}, 1);
            chk("stream_in_ready", {31'd0, o_in_ready}, 0);
            chk("stream_beat", {22'd0, o_data, o_sop, o_eop},
                {22'd0, 8'(k), 1'b0, k == DIM});
        end
        tick();
        chk("end_valid", {31'd0, o_valid}, 0);
        chk("end_in_ready", {31'd0, o_in_ready}, 1);
        i_valid = 1'b0; i_sop = 1'b0;
        mon_en = 1'b1;
        drive_frame(8'hB0);
        for (int k = 0; k < DIM; k++)
            exp_q.push_back({8'hB0 + 8'(k), k == 0, k == DIM - 1});
        drain_check("after_aa");
        mon_en = 1'b0;

        // Reset after the third output beat has transferred.
        drive_frame(8'h21);
        wait_valid("rst_seq_valid");
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_valid", {31'd0, o_valid}, 0);
        chk("midrst_in_ready", {31'd0, o_in_ready}, 1);
        chk("midrst_eop", {31'd0, o_eop}, 0);
        chk("midrst_data", {24'd0, o_data}, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("postrst_quiet", {30'd0, o_valid, o_eop}, 0);
        end

        // Freeze mid-SEND with clk_en low.
        drive_frame(8'h31);
        wait_valid("cken_seq_valid");
        repeat (2) tick();
        clk_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("frozen_beat", {21'd0, o_valid, o_data, o_sop, o_eop},
                {21'd0, 1'b1, 8'h33, 1'b0, 1'b0});
        end
        clk_en = 1'b1;
        for (int k = 4; k <= DIM; k++) begin
            tick();
            chk("resume_beat", {21'd0, o_valid, o_data, o_sop, o_eop},
                {21'd0, 1'b1, 8'h30 + 8'(k), 1'b0, k == DIM});
        end
        tick();
        chk("resume_end", {31'd0, o_valid}, 0);

        // Random frames, random backpressure, occasional framing faults.
        m_idx = -1;
        mon_en = 1'b1;
        rr_en = 1'b1;
        for (int f = 0; f < 30; f++) begin
            beat_t fr[DIM];
            int j;
            if ($urandom_range(0, 7) == 0)
                put({8'($urandom), 1'b0, 1'($urandom_range(0, 1))}, 1'b1);
            for (int i = 0; i < DIM; i++)
                fr[i] = {8'($urandom), i % CL == 0, i % CL == CL - 1};
            if ($urandom_range(0, 3) == 0) begin
                j = $urandom_range(0, DIM - 1);
                if ($urandom_range(0, 1) == 1) fr[j].s = ~fr[j].s;
                else fr[j].e = ~fr[j].e;
            end
            for (int i = 0; i < DIM; i++) begin
                put(fr[i], 1'b1);
                if ($urandom_range(0, 3) == 0) begin
                    i_valid = 1'b0;
                    tick();
                end
            end
            i_valid = 1'b0;
            if (f % 5 == 4) drain_check("rand");
        end
        rr_en = 1'b0;
        mon_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/flatten_packetizer.md
FLATTEN_PACKETIZER -- requirements
Module: flatten_packetizer

Interface
REQ-001 SHALL have parameter PIX_WIDTH, default 8, pixel width in bits.
REQ-002 SHALL have parameter N_CH, default 8, number of feature-map channels per frame.
REQ-003 SHALL have parameter CH_LEN, default 25, pixels per channel; IN_DIMENSION = N_CH*CH_LEN (default 200).
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port clk_en  input  1  clock enable; state frozen when 0.
REQ-007 SHALL have ports i_data  input  PIX_WIDTH, i_valid  input  1, i_sop  input  1, i_eop  input  1: per-channel input stream, sop/eop frame one channel.
REQ-008 SHALL have port o_in_ready  output  1  registered; upstream beats accepted only while high.
REQ-009 SHALL have ports o_data  output  PIX_WIDTH, o_valid  output  1, o_sop  output  1, o_eop  output  1: flattened output packet to fully-connected layer.
REQ-010 SHALL have port i_ready  input  1  downstream ready; output beat transfers when o_valid && i_ready.
REQ-011 SHALL have port o_err  output  1  one-cycle framing-error pulse.

Function
REQ-012 SHALL update all registers only on cycles with clk_en=1; with clk_en=0 all outputs hold.
REQ-013 SHALL implement states IDLE, FILL, SEND.
REQ-014 IDLE: o_in_ready=1; beat with i_valid && i_sop written to buf[0], go FILL; i_valid without i_sop ignored.
REQ-015 FILL: each accepted beat written to buf[wr_ptr], wr_ptr increments; address = ch*CH_LEN + pos.
REQ-016 FILL framing: i_sop required exactly at pos 0, i_eop exactly at pos CH_LEN-1; any mismatch (missing, early, late, i_sop && i_eop with CH_LEN>1) -> o_err=1 one cycle, frame discarded, go IDLE.
REQ-017 Accepted i_eop of channel N_CH-1 -> SEND; o_in_ready low from next cycle until SEND ends; beats presented while low ignored.
REQ-018 SEND: emit buf[0..IN_DIMENSION-1] in write order; o_sop=1 only on index 0, o_eop=1 only on index IN_DIMENSION-1.
REQ-019 First o_valid SHALL rise on the 2nd enabled cycle after the final input eop beat (1 transition + 1 buffer read).
REQ-020 With i_ready=1 continuously, SHALL emit one beat per enabled cycle, no bubbles.
REQ-021 While o_valid && !i_ready, o_data/o_sop/o_eop SHALL hold stable; no beat lost or duplicated when i_ready toggles any cycle.
REQ-022 After eop beat transfers: o_valid=0 next cycle, go IDLE, o_in_ready=1 same cycle as IDLE.
REQ-023 Upstream i_valid with sop in same cycle as SEND->IDLE transition SHALL be ignored (o_in_ready still low).
REQ-024 Data passes unmodified (no arithmetic, width PIX_WIDTH in and out).

Reset
REQ-025 rst_n=0 SHALL take priority over clk_en and force IDLE, wr_ptr=rd_ptr=0.
REQ-026 Reset values: o_valid=0, o_sop=0, o_eop=0, o_err=0, o_in_ready=1, o_data=0.
REQ-027 Reset mid-FILL or mid-SEND SHALL abandon the frame; no partial packet or eop emitted afterwards.
REQ-028 Buffer contents SHALL NOT be reset.

Structure
REQ-029 State enum (IDLE/FILL/SEND, one-hot) and default PIX_WIDTH/N_CH/CH_LEN SHALL live in shared package cnn_pkg.
REQ-030 Buffer SHALL be sub-module pkt_buffer: simple dual-port RAM, depth IN_DIMENSION, 1-cycle registered read, clk_en-gated.
REQ-031 Output holding under backpressure SHALL use one skid register in flatten_packetizer.

Verification
REQ-032 N_CH=2, CH_LEN=3, inputs 1,2,3 | 4,5,6 correctly framed, i_ready=1 -> outputs 1..6 on consecutive cycles, o_sop on 1, o_eop on 6, first o_valid 2 cycles after input eop.
REQ-033 Same frame, i_ready random 50% -> exactly 6 transfers, sequence 1..6, values stable during stalls.
REQ-034 Channel 0 i_eop at pos 1 -> o_err pulse one cycle, no o_valid, next correct frame outputs normally.
REQ-035 Beats sent while o_in_ready=0 during SEND (value 0xAA) -> never appear in output.
REQ-036 rst_n=0 after 3rd output beat -> o_valid=0 next cycle, o_in_ready=1, no o_eop.
REQ-037 clk_en=0 for 5 cycles mid-SEND -> outputs frozen, sequence resumes unchanged.
